// File: rtl/sample_window_queue.sv
// sample_window_queue
//
// Decimating sample capture buffer with windowed replay. Incoming samples are
// decimated by DECIM, written into a circular DEPTH x DATA_W RAM, and once
// WIN samples are held, every new stored sample requests a replay of the most
// recent WIN samples, oldest first. A request that arrives while a replay is
// running is held in a single pending slot and serviced back-to-back when the
// current replay ends. Further requests while the slot is occupied are dropped
// and flagged on overrun.
//
// Optional feature: define SWQ_REVERSE_EN to add the rev input. rev is sampled
// when a replay starts; rev = 1 replays newest to oldest.
//
// Parameters
//   DATA_W  sample width
//   ADDR_W  RAM address width, DEPTH = 2**ADDR_W
//   WIN     samples per replay, 1 <= WIN <= DEPTH-4
//   DECIM   keep one of every DECIM strobes, DECIM >= 1
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   new_smpl    incoming sample
//   wrt_smpl    one-cycle sample strobe
//   smpl_out    replayed sample (registered, held while smpl_vld is low)
//   smpl_vld    smpl_out carries a replayed sample this cycle
//   sequencing  replay in progress, including the final read-data cycle
//   full        at least WIN samples stored
//   overrun     one-cycle pulse when a replay request is dropped
//   rev         (SWQ_REVERSE_EN only) replay direction, 1 = newest first

module sample_window_queue #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int WIN    = 1020,
    parameter int DECIM  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] new_smpl,
    input  logic              wrt_smpl,
    output logic [DATA_W-1:0] smpl_out,
    output logic              smpl_vld,
    output logic              sequencing,
    output logic              full,
    output logic              overrun
`ifdef SWQ_REVERSE_EN
    ,
    input  logic              rev
`endif
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam int                DEC_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DEC_W-1:0]  DEC_LAST = DEC_W'(DECIM - 1);
    localparam logic [ADDR_W-1:0] WIN_A    = ADDR_W'(WIN);
    localparam logic [ADDR_W-1:0] WIN_LAST = ADDR_W'(WIN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DEC_W-1:0]    r_dec_cnt;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W-1:0]   r_rd_cnt;
    logic [ADDR_W-1:0]   r_fill;
    logic                r_pending;
    logic                r_rev;
    logic [DATA_W-1:0]   r_smpl_out;
    logic                r_smpl_vld;
    logic                r_overrun;

    logic                w_store;
    logic                w_win_ready;
    logic [ADDR_W-1:0]   w_wr_nxt;
    logic [ADDR_W-1:0]   w_start_ptr;
    logic                w_rev_in;
    logic                w_rd_en;
    logic                w_last_rd;
    logic                w_restart;
    logic                w_start;

`ifdef SWQ_REVERSE_EN
    assign w_rev_in = rev;
`else
    assign w_rev_in = 1'b0;
`endif

    // Store event: the strobe that completes a decimation period.
    assign w_store     = wrt_smpl && (r_dec_cnt == DEC_LAST);
    // Write pointer as it stands after this cycle's store, so a new window
    // always ends on the most recently written sample.
    assign w_wr_nxt    = w_store ? r_wr_ptr + 1'b1 : r_wr_ptr;
    // fill never exceeds WIN, so fill >= WIN-1 means this store leaves it at WIN.
    assign w_win_ready = w_store && (r_fill >= WIN_LAST);
    assign w_start_ptr = w_rev_in ? w_wr_nxt - 1'b1 : w_wr_nxt - WIN_A;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment at the top of each always_comb keeps every
    // path driven, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_win_ready) w_state_nxt = SEQ;
            SEQ:  if (w_last_rd && !w_restart) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_en   = (r_state == SEQ);
        w_last_rd = w_rd_en && (r_rd_cnt == WIN_LAST);
        // A pending request, or one arriving on the last read itself, chains
        // straight into the next replay so smpl_vld has no gap.
        w_restart = w_last_rd && (r_pending || w_store);
        w_start   = ((r_state == IDLE) && w_win_ready) || w_restart;
    end

    // ------------------------------------------------------------------
    // Sample RAM
    // ------------------------------------------------------------------
    // NOTE: the RAM has no reset so it maps onto block memory; its contents
    // are only ever read inside a window that has been written.
    always_ff @(posedge clk) begin
        if (rst_n && w_store) begin
            r_mem[r_wr_ptr] <= new_smpl;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: decimation, pointers, fill, pending, registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dec_cnt  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_cnt   <= '0;
            r_fill     <= '0;
            r_pending  <= 1'b0;
            r_rev      <= 1'b0;
            r_smpl_out <= '0;
            r_smpl_vld <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (wrt_smpl) begin
                r_dec_cnt <= (r_dec_cnt == DEC_LAST) ? '0 : r_dec_cnt + 1'b1;
            end

            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_fill != WIN_A) begin
                    r_fill <= r_fill + 1'b1;
                end
            end

            if (w_start) begin
                r_rd_ptr <= w_start_ptr;
                r_rd_cnt <= '0;
                r_rev    <= w_rev_in;
            end else if (w_rd_en) begin
                r_rd_ptr <= r_rev ? r_rd_ptr - 1'b1 : r_rd_ptr + 1'b1;
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end

            // Single request slot: consumed by a chained restart, set by any
            // store that lands mid-replay.
            if (w_restart) begin
                r_pending <= 1'b0;
            end else if (w_rd_en && w_store) begin
                r_pending <= 1'b1;
            end

            r_overrun  <= w_rd_en && w_store && r_pending;
            r_smpl_vld <= w_rd_en;
            if (w_rd_en) begin
                r_smpl_out <= r_mem[r_rd_ptr];
            end
        end
    end

    assign smpl_out   = r_smpl_out;
    assign smpl_vld   = r_smpl_vld;
    assign sequencing = (r_state == SEQ) || r_smpl_vld;
    assign full       = (r_fill == WIN_A);
    assign overrun    = r_overrun;

endmodule
